// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Decodes the instruction format and sign-extended immediate of an RV32I
//   instruction word, then passes the result through a 2-entry skid buffer
//   (output register plus one skid register) with valid/ready handshakes on
//   both sides. The latency is one cycle, and the buffer can sustain one
//   instruction per cycle.
//
// Parameters
//   M          extended immediate width in bits (M >= 32)
//
// Ports
//   i_clk      clock; all state updates on its rising edge
//   i_rst      asynchronous active-high reset
//   i_valid    upstream instruction valid
//   o_ready    block can accept an instruction (registered)
//   i_instr    RV32I instruction word
//   o_valid    output entry valid (registered)
//   i_ready    downstream accepts the output entry
//   o_imm      decoded, sign-extended immediate (0 for R and BAD formats)
//   o_fmt      format: R=0, I=1, S=2, B=3, U=4, J=5, BAD=7
//   o_illegal  opcode not recognised
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int M = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_instr,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_imm,
  output logic [2:0]   o_fmt,
  output logic         o_illegal
);

  // Buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Format encodings
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_BAD = 3'd7;

  // Recognised opcodes
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [M-1:0] imm;
    logic [2:0]   fmt;
    logic         ill;
  } entry_t;

  // Combinational decode of one instruction word into a buffer entry.
  // The immediate is first built as a 32-bit value, and its bit 31 (which is
  // always instr[31] for I/S/B/U/J) is then replicated up to M bits. This
  // avoids a zero-width replication when M == 32.
  function automatic entry_t decode(input logic [31:0] instr);
    entry_t      e;
    logic [31:0] imm32;
    e.fmt = FMT_BAD;
    e.ill = 1'b1;
    imm32 = 32'd0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        e.fmt = FMT_I;
        e.ill = 1'b0;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        e.fmt = FMT_S;
        e.ill = 1'b0;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        e.fmt = FMT_B;
        e.ill = 1'b0;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        e.fmt = FMT_U;
        e.ill = 1'b0;
        imm32 = {instr[31:12], 12'd0};
      end
      OP_JAL: begin
        e.fmt = FMT_J;
        e.ill = 1'b0;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      end
      OP_REG: begin
        e.fmt = FMT_R;
        e.ill = 1'b0;
        imm32 = 32'd0;
      end
      default: begin
        e.fmt = FMT_BAD;
        e.ill = 1'b1;
        imm32 = 32'd0;
      end
    endcase
    e.imm       = {M{imm32[31]}};
    e.imm[31:0] = imm32;
    return e;
  endfunction

  logic [1:0] state_q, state_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  entry_t     dec_s;
  logic       accept_s;
  logic       pop_s;

  assign dec_s    = decode(i_instr);
  assign accept_s = i_valid && ready_q;
  assign pop_s    = valid_q && i_ready;

  // Next-state and entry movement for the skid buffer
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_HALF;
          out_d   = dec_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HALF: begin
        if (accept_s && !pop_s) begin
          state_d = ST_FULL;
          skid_d  = dec_s;
        end else if (pop_s && !accept_s) begin
          state_d = ST_EMPTY;
        end else if (accept_s && pop_s) begin
          state_d = ST_HALF;
          out_d   = dec_s;
        end else begin
          state_d = ST_HALF;
        end
      end
      ST_FULL: begin
        // o_ready is low here, so a pop is the only possible event
        if (pop_s) begin
          state_d = ST_HALF;
          out_d   = skid_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        // Unused encoding: recover to an empty buffer
        state_d = ST_EMPTY;
      end
    endcase
    ready_d = (state_d != ST_FULL);
    valid_d = (state_d != ST_EMPTY);
  end

  // State and data registers; reset empties the buffer immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_imm     = out_q.imm;
  assign o_fmt     = out_q.fmt;
  assign o_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
//   Self-checking bench for imm_gen_stage. It runs a table of known
//   instruction/immediate pairs, then directed backpressure and reset-in-FULL
//   sequences, then a sweep of every 12-bit I immediate. It ends with a random
//   valid/ready run scored against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

  localparam int M = 32;

  logic         i_clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_instr;
  logic         o_valid;
  logic         i_ready;
  logic [M-1:0] o_imm;
  logic [2:0]   o_fmt;
  logic         o_illegal;

  int vectors     = 0;
  int miscompares = 0;

  imm_gen_stage #(.M(M)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_instr   (i_instr),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_imm     (o_imm),
    .o_fmt     (o_fmt),
    .o_illegal (o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [M-1:0] imm;
    logic [2:0]   fmt;
    logic         ill;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference decode taken directly from the format rules: each immediate
  // field is gathered and then interpreted as a signed number of M bits.
  function automatic exp_t ref_decode(input logic [31:0] x);
    exp_t                e;
    logic signed [M-1:0] s;
    s     = '0;
    e.ill = 1'b0;
    e.fmt = 3'd7;
    case (x[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.fmt = 3'd1; s = M'($signed(x[31:20]));
      end
      7'b0100011: begin
        e.fmt = 3'd2; s = M'($signed({x[31:25], x[11:7]}));
      end
      7'b1100011: begin
        e.fmt = 3'd3; s = M'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; s = M'($signed({x[31:12], 12'd0}));
      end
      7'b1101111: begin
        e.fmt = 3'd5; s = M'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
      end
      7'b0110011: begin
        e.fmt = 3'd0; s = '0;
      end
      default: begin
        e.fmt = 3'd7; e.ill = 1'b1; s = '0;
      end
    endcase
    e.imm = s;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 10))
      0:       op = 7'b0010011;
      1:       op = 7'b0000011;
      2:       op = 7'b1100111;
      3:       op = 7'b0100011;
      4:       op = 7'b1100011;
      5:       op = 7'b0110111;
      6:       op = 7'b0010111;
      7:       op = 7'b1101111;
      8:       op = 7'b0110011;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  vec_t tbl[12];
  exp_t q[$];
  exp_t e;
  logic acc;
  logic pop;
  logic [11:0] f;
  logic [63:0] exp_up;

  initial begin
    tbl[0]  = '{32'hFF600093, 32'hFFFFFFF6, 3'd1, 1'b0}; // addi x1,x0,-10
    tbl[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0}; // store, -4
    tbl[2]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0}; // lui
    tbl[3]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0}; // jal -4
    tbl[4]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1}; // illegal
    tbl[5]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0}; // beq -4
    tbl[6]  = '{32'h003100B3, 32'h00000000, 3'd0, 1'b0}; // add
    tbl[7]  = '{32'h00812283, 32'h00000008, 3'd1, 1'b0}; // lw x5,8(x2)
    tbl[8]  = '{32'h7FF08067, 32'h000007FF, 3'd1, 1'b0}; // jalr max +imm
    tbl[9]  = '{32'h80000017, 32'h80000000, 3'd4, 1'b0}; // auipc, msb set
    tbl[10] = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0}; // jal +8
    tbl[11] = '{32'h00000000, 32'h00000000, 3'd7, 1'b1}; // all-zero word

    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_instr = 32'd0;

    // Reset must take effect with no clock edge
    #1 i_rst = 1'b1;
    #1;
    check("reset_valid",   64'(o_valid),   64'd0);
    check("reset_ready",   64'(o_ready),   64'd1);
    check("reset_imm",     64'(o_imm),     64'd0);
    check("reset_fmt",     64'(o_fmt),     64'd0);
    check("reset_illegal", 64'(o_illegal), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    // Table-driven single transfers
    for (int i = 0; i < 12; i++) begin
      i_valid = 1'b1;
      i_instr = tbl[i].instr;
      i_ready = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_instr = 32'hDEADBEEF; // must be ignored while i_valid is low
      check($sformatf("tbl%0d_valid", i),   64'(o_valid),   64'd1);
      check($sformatf("tbl%0d_imm", i),     64'(o_imm),     64'(tbl[i].imm));
      check($sformatf("tbl%0d_fmt", i),     64'(o_fmt),     64'(tbl[i].fmt));
      check($sformatf("tbl%0d_illegal", i), 64'(o_illegal), 64'(tbl[i].ill));
      @(negedge i_clk);
      check($sformatf("tbl%0d_drain", i),   64'(o_valid),   64'd0);
    end

    // Backpressure: two accepted, third held, then drained in order
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = 32'h00100093;               // A: addi imm 1
    @(negedge i_clk);
    check("bp_ready_after_1", 64'(o_ready), 64'd1);
    i_instr = 32'h123452B7;               // B: lui
    @(negedge i_clk);
    check("bp_ready_after_2", 64'(o_ready), 64'd0);
    check("bp_head_A",        64'(o_imm),   64'h00000001);
    i_instr = 32'hFFDFF06F;               // C: jal -4, held
    @(negedge i_clk);
    check("bp_still_full",    64'(o_ready), 64'd0);
    check("bp_hold_imm",      64'(o_imm),   64'h00000001);
    check("bp_hold_fmt",      64'(o_fmt),   64'd1);
    i_ready = 1'b1;                        // A leaves at the next edge
    @(negedge i_clk);
    check("bp_out_B_valid",   64'(o_valid), 64'd1);
    check("bp_out_B_imm",     64'(o_imm),   64'h12345000);
    check("bp_out_B_fmt",     64'(o_fmt),   64'd4);
    check("bp_ready_again",   64'(o_ready), 64'd1);
    @(negedge i_clk);                      // C accepted while B popped
    i_valid = 1'b0;
    check("bp_out_C_valid",   64'(o_valid), 64'd1);
    check("bp_out_C_imm",     64'(o_imm),   64'hFFFFFFFC);
    check("bp_out_C_fmt",     64'(o_fmt),   64'd5);
    @(negedge i_clk);
    check("bp_drained",       64'(o_valid), 64'd0);

    // Reset while FULL discards both entries
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = 32'h00100093;
    @(negedge i_clk);
    i_instr = 32'h123452B7;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("full_before_reset", 64'(o_ready), 64'd0);
    #2 i_rst = 1'b1;
    #1;
    check("rst_full_valid", 64'(o_valid), 64'd0);
    check("rst_full_ready", 64'(o_ready), 64'd1);
    check("rst_full_imm",   64'(o_imm),   64'd0);
    check("rst_full_fmt",   64'(o_fmt),   64'd0);
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 1'b1;
    i_instr = 32'h0000007F;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("post_rst_valid",   64'(o_valid),   64'd1);
    check("post_rst_illegal", 64'(o_illegal), 64'd1);
    check("post_rst_fmt",     64'(o_fmt),     64'd7);
    @(negedge i_clk);
    check("post_rst_no_stale", 64'(o_valid), 64'd0);

    // Sweep every 12-bit I immediate at full throughput
    i_ready = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      f       = k[11:0];
      i_valid = 1'b1;
      i_instr = {f, 5'd3, 3'b000, 5'd7, 7'b0010011};
      @(negedge i_clk);
      exp_up = f[11] ? ((64'd1 << (M - 12)) - 64'd1) : 64'd0;
      check("sweep_valid", 64'(o_valid),      64'd1);
      check("sweep_low",   64'(o_imm[11:0]),  64'(f));
      check("sweep_high",  64'(o_imm[M-1:12]), exp_up);
    end
    i_valid = 1'b0;
    @(negedge i_clk);

    // Random valid/ready traffic against the queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      check("rnd_valid", 64'(o_valid), 64'(q.size() != 0));
      check("rnd_ready", 64'(o_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        check("rnd_imm",     64'(o_imm),     64'(q[0].imm));
        check("rnd_fmt",     64'(o_fmt),     64'(q[0].fmt));
        check("rnd_illegal", 64'(o_illegal), 64'(q[0].ill));
      end
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_instr = rand_instr();
      acc = i_valid && (q.size() < 2);
      pop = (q.size() != 0) && i_ready;
      e   = ref_decode(i_instr);
      @(posedge i_clk);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      @(negedge i_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
